_eeprom_page: RTL and testbench

_EEPROM_PAGE -- requirements
Module: _eeprom_page

---
 rtl/_eeprom_pkg.sv | 17 +
 rtl/_eeprom_page_buf.sv | 34 +++
 rtl/_eeprom_page.sv | 132 +++++++++++++
 tb/tb__eeprom_page.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/_eeprom_pkg.sv
// Shared state encoding and default timing for the page-mode EEPROM model.
package _eeprom_pkg;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_LOAD_ENC = 2'd1;
   localparam logic [1:0] ST_PROG_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_LOAD = ST_LOAD_ENC,
      ST_PROG = ST_PROG_ENC
   } state_e;

   localparam int TBLC_DEF = 16;
   localparam int TWC_DEF  = 64;

endpackage

// File: rtl/_eeprom_page_buf.sv
// One-page write buffer: data slots plus a valid mask, exposed whole so the
// commit can copy every loaded slot in a single clock.
module _eeprom_page_buf #(
   parameter int PW = 6,
   parameter int DW = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      we_i,
   input  logic                      clr_i,
   input  logic [PW-1:0]             waddr_i,
   input  logic [DW-1:0]             wdata_i,
   output logic [2**PW-1:0][DW-1:0]  data_o,
   output logic [2**PW-1:0]          valid_o
);

   logic [2**PW-1:0][DW-1:0] data_q;
   logic [2**PW-1:0]         valid_q;

   // Slot data needs no reset: it is only ever read behind its valid bit.
   always_ff @(posedge clk_i) begin
      if (we_i) data_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    valid_q <= '0;
      else if (clr_i) valid_q <= '0;
      else if (we_i)  valid_q[waddr_i] <= 1'b1;
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/_eeprom_page.sv
// Behavioural page-mode parallel EEPROM: byte-load window, timed internal
// program cycle, and data-polling / toggle status reads while busy.
module _eeprom_page
   import _eeprom_pkg::*;
#(
   parameter int AW   = 15,
   parameter int DW   = 8,
   parameter int PW   = 6,
   parameter int TBLC = TBLC_DEF,
   parameter int TWC  = TWC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] a,
   input  logic          ce,
   input  logic          oe,
   input  logic          we,
   inout  wire  [DW-1:0] io,
   output logic          busy
);

   localparam int NS   = 2**PW;
   localparam int TMAX = (TBLC > TWC) ? TBLC : TWC;
   localparam int TW   = $clog2(TMAX + 1);

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [AW-PW-1:0] page_q, page_d;
   logic            ld_q, ld_d;
   logic            tgl_q, tgl_d;

   logic            strobe, rd, buf_we, commit;
   logic [NS-1:0][DW-1:0] buf_data;
   logic [NS-1:0]   buf_valid;
   logic [DW-1:0]   stat, rd_data;

   // Erased array powers up all-ones; reset never touches it.
   logic [DW-1:0]   mem_q [2**AW] = '{default: {DW{1'b1}}};

   assign strobe = !ce && !we && oe;
   assign rd     = !ce && !oe && we;
   assign busy   = (state_q == ST_PROG);

   _eeprom_page_buf #(.PW(PW), .DW(DW)) u_buf (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (buf_we),
      .clr_i   (commit),
      .waddr_i (a[PW-1:0]),
      .wdata_i (io),
      .data_o  (buf_data),
      .valid_o (buf_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         page_q  <= '0;
         ld_q    <= 1'b0;
         tgl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         page_q  <= page_d;
         ld_q    <= ld_d;
         tgl_q   <= tgl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      page_d  = page_q;
      ld_d    = ld_q;
      tgl_d   = tgl_q;
      buf_we  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: if (strobe) begin
            page_d  = a[AW-1:PW];
            buf_we  = 1'b1;
            ld_d    = io[DW-1];
            timer_d = TW'(TBLC);
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // Off-page strobes fall through and let the window keep expiring.
            if (strobe && (a[AW-1:PW] == page_q)) begin
               buf_we  = 1'b1;
               ld_d    = io[DW-1];
               timer_d = TW'(TBLC);
            end else if (timer_q <= TW'(1)) begin
               timer_d = TW'(TWC);
               state_d = ST_PROG;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_PROG: begin
            if (rd) tgl_d = ~tgl_q;
            if (timer_q <= TW'(1)) begin
               commit  = 1'b1;
               timer_d = '0;
               tgl_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < NS; i++) begin
            if (buf_valid[i]) mem_q[{page_q, PW'(i)}] <= buf_data[i];
         end
      end
   end

   always_comb begin
      stat       = '0;
      stat[DW-1] = ~ld_q;
      stat[DW-2] = tgl_q;
   end

   assign rd_data = (state_q == ST_PROG) ? stat : mem_q[a];
   assign io      = rd ? rd_data : {DW{1'bz}};

endmodule

// File: tb/tb__eeprom_page.sv
// Directed bench for _eeprom_page: byte/page writes, timing windows, status
// polling, off-page and busy-time strobes, and reset during program.
module tb__eeprom_page;

   localparam int AW = 15, DW = 8, PW = 6, TBLC = 16, TWC = 64;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] exp;
   } wvec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
   } rvec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b1, oe = 1'b1, we = 1'b1;
   logic [AW-1:0] a = '0;
   logic [DW-1:0] io_drv = '0;
   logic          io_en = 1'b0;
   wire  [DW-1:0] io;
   logic          busy;

   int errors = 0;
   int checks = 0;

   assign io = io_en ? io_drv : {DW{1'bz}};

   _eeprom_page #(.AW(AW), .DW(DW), .PW(PW), .TBLC(TBLC), .TWC(TWC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .ce    (ce),
      .oe    (oe),
      .we    (we),
      .io    (io),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d);
      @(negedge clk);
      a = ad; io_drv = d; io_en = 1'b1; oe = 1'b1; ce = 1'b0; we = 1'b0;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      ce = 1'b1; we = 1'b1; oe = 1'b1; io_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] ad, output logic [DW-1:0] d);
      @(negedge clk);
      io_en = 1'b0; a = ad; we = 1'b1; ce = 1'b0; oe = 1'b0;
      #1 d = io;
   endtask

   task automatic wait_busy(input logic lvl, output int n);
      n = 0;
      while (busy !== lvl && n < 300) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic quiet_window(input string nm);
      int hits;
      hits = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy) hits++;
      end
      chk(nm, hits, 0);
   endtask

   initial begin
      wvec_t wv[4];
      rvec_t rv[8];
      logic [DW-1:0] d;
      logic exp_t;
      int n;

      wv[0] = '{15'h0123, 8'h5A, 8'h5A};
      wv[1] = '{15'h7FFF, 8'h00, 8'h00};
      wv[2] = '{15'h0000, 8'hC3, 8'hC3};
      wv[3] = '{15'h1234, 8'h81, 8'h81};

      rv[0] = '{15'h0040, 8'h00};
      rv[1] = '{15'h0041, 8'h01};
      rv[2] = '{15'h005A, 8'h1A};
      rv[3] = '{15'h007F, 8'h3F};
      rv[4] = '{15'h0080, 8'hFF};
      rv[5] = '{15'h003F, 8'hFF};
      rv[6] = '{15'h0123, 8'h5A};
      rv[7] = '{15'h7FFF, 8'h00};

      // Reset state and erased array
      repeat (3) @(negedge clk);
      chk("rst_busy_low", busy, 0);
      rst_n = 1'b1;
      rd(15'h0000, d); chk("erased_0000", d, 8'hFF);
      rd(15'h7FFF, d); chk("erased_7FFF", d, 8'hFF);
      bus_idle();

      // Single-byte writes: load window, program window, readback
      for (int i = 0; i < 4; i++) begin
         wr(wv[i].addr, wv[i].data);
         bus_idle();
         wait_busy(1'b1, n); chk($sformatf("byte%0d_busy_lat", i), n, TBLC);
         wait_busy(1'b0, n); chk($sformatf("byte%0d_busy_len", i), n, TWC);
         rd(wv[i].addr, d);  chk($sformatf("byte%0d_rd", i), d, wv[i].exp);
         bus_idle();
      end

      // Full page on consecutive cycles -> exactly one program window
      for (int i = 0; i < 64; i++) wr(15'h0040 + AW'(i), DW'(i));
      bus_idle();
      wait_busy(1'b1, n); chk("page_busy_lat", n, TBLC);
      wait_busy(1'b0, n); chk("page_busy_len", n, TWC);
      quiet_window("page_one_window");
      for (int i = 0; i < 8; i++) begin
         rd(rv[i].addr, d);
         chk($sformatf("page_rd_%0h", rv[i].addr), d, rv[i].exp);
         bus_idle();
      end

      // Status polling while programming
      wr(15'h0100, 8'h5A);
      bus_idle();
      wait_busy(1'b1, n); chk("poll_busy_lat", n, TBLC);
      rd(15'h0100, d); chk("poll_first", d, 8'h80);
      exp_t = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         exp_t = ~exp_t;
         chk($sformatf("poll_%0d", k), io, {1'b1, exp_t, 6'b0});
      end
      bus_idle();
      wait_busy(1'b0, n); chk("poll_done", busy, 0);
      rd(15'h0100, d); chk("poll_after_commit", d, 8'h5A);
      bus_idle();

      // Overwrite in buffer, plus an off-page strobe that must not reload the window
      wr(15'h0046, 8'h88);
      wr(15'h0045, 8'h33);
      wr(15'h0045, 8'h77);
      wr(15'h0080, 8'h11);
      bus_idle();
      wait_busy(1'b1, n); chk("offpage_busy_lat", n, TBLC - 1);
      wait_busy(1'b0, n); chk("offpage_busy_len", n, TWC);
      rd(15'h0045, d); chk("last_wins_0045", d, 8'h77); bus_idle();
      rd(15'h0046, d); chk("loaded_0046", d, 8'h88);    bus_idle();
      rd(15'h0080, d); chk("offpage_0080", d, 8'hFF);   bus_idle();
      rd(15'h0047, d); chk("unloaded_0047", d, 8'h07);  bus_idle();

      // Strobe during program is ignored and does not stretch busy
      wr(15'h0301, 8'h42);
      bus_idle();
      wait_busy(1'b1, n); chk("prog_strobe_lat", n, TBLC);
      wr(15'h0200, 8'h99);
      bus_idle();
      wait_busy(1'b0, n); chk("prog_strobe_len", n, TWC - 1);
      quiet_window("prog_strobe_no_load");
      rd(15'h0200, d); chk("prog_strobe_0200", d, 8'hFF); bus_idle();
      rd(15'h0301, d); chk("prog_strobe_0301", d, 8'h42); bus_idle();

      // Buffered data invisible before commit; reset mid-program discards it
      wr(15'h0123, 8'hA5);
      bus_idle();
      rd(15'h0123, d); chk("load_not_visible", d, 8'h5A);
      bus_idle();
      wait_busy(1'b1, n); chk("rst_prog_entered", busy, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("rst_busy_async", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rd(15'h0123, d); chk("rst_no_commit", d, 8'h5A);
      bus_idle();
      wr(15'h0124, 8'h3C);
      bus_idle();
      wait_busy(1'b1, n); chk("post_rst_busy_lat", n, TBLC);
      wait_busy(1'b0, n); chk("post_rst_busy_len", n, TWC);
      rd(15'h0124, d); chk("post_rst_0124", d, 8'h3C); bus_idle();
      rd(15'h0123, d); chk("post_rst_0123", d, 8'h5A); bus_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
